sys_bus_initiator: RTL

- Synthesizable system-bus initiator. It converts a valid/ready command port into single-transaction sys-bus read/write cycles, with an ack timeout.
- It can also sweep a block of slave registers autonomously at a fixed interval (e.g. AMS XADC readouts at 0x30..0x38) and cache the results.
- Sits between a control master (CPU bridge or sequencer) and any sys-bus responder such as red_pitaya_ams.

---
 rtl/sys_bus_initiator.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/sys_bus_initiator.sv
// -----------------------------------------------------------------------------
// sys_bus_initiator
//
// Turns a valid/ready command port into single sys-bus read/write cycles and,
// when enabled, sweeps a small block of slave registers at a fixed interval,
// caching the words it reads.
//
// Ports
//   clk_i, rst_i         clock, asynchronous active-high reset
//   cmd_valid_i/ready_o  command handshake (accepted when both are high)
//   cmd_we_i             1 = write, 0 = read
//   cmd_addr_i/wdata_i   byte address and write data of the command
//   rsp_valid_o          one-cycle pulse when a command completes
//   rsp_rdata_o          read data (0 on write or timeout), held until next rsp
//   rsp_err_o/tout_o     responder error or timeout / timeout only
//   poll_en_i            enables the periodic sweep
//   poll_data_o          cached words, word i at bits [32i+31:32i]
//   poll_upd_o           one-cycle pulse at the end of each sweep
//   poll_err_o           last sweep saw an error or timeout
//   sys_addr_o/wdata_o   bus address and write data
//   sys_wen_o/ren_o      one-cycle write / read strobe
//   sys_rdata_i/err_i/ack_i  responder read data, error and acknowledge
// -----------------------------------------------------------------------------
module sys_bus_initiator #(
   parameter int unsigned TIMEOUT     = 255,
   parameter int unsigned POLL_PERIOD = 20000,
   parameter int unsigned POLL_NUM    = 3,
   parameter logic [31:0] POLL_BASE   = 32'h30
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     cmd_valid_i,
   output logic                     cmd_ready_o,
   input  logic                     cmd_we_i,
   input  logic [31:0]              cmd_addr_i,
   input  logic [31:0]              cmd_wdata_i,
   output logic                     rsp_valid_o,
   output logic [31:0]              rsp_rdata_o,
   output logic                     rsp_err_o,
   output logic                     rsp_tout_o,
   input  logic                     poll_en_i,
   output logic [POLL_NUM*32-1:0]   poll_data_o,
   output logic                     poll_upd_o,
   output logic                     poll_err_o,
   output logic [31:0]              sys_addr_o,
   output logic [31:0]              sys_wdata_o,
   output logic                     sys_wen_o,
   output logic                     sys_ren_o,
   input  logic [31:0]              sys_rdata_i,
   input  logic                     sys_err_i,
   input  logic                     sys_ack_i
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int PW = $clog2(POLL_PERIOD);
   localparam int KW = (POLL_NUM > 1) ? $clog2(POLL_NUM) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STROBE = 2'd1,
      WAIT   = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t          state;
   logic [TW-1:0]   tcnt;
   logic            we;
   logic            is_poll;
   logic            sweep_err;
   logic [KW-1:0]   idx;
   logic [PW-1:0]   poll_timer;
   logic            poll_pend;

   logic            accept;
   logic            sweep_start;
   logic            bus_resp;
   logic            tout_hit;
   logic            xfer_end;
   logic            res_err;
   logic [31:0]     res_rdata;
   logic            last_word;
   logic            slot_we;

   // cmd_ready_o is registered and tracks IDLE, so it also gates acceptance;
   // this keeps the handshake honest in the first cycle after reset.
   always_comb begin
      accept      = (state == IDLE) && cmd_ready_o && cmd_valid_i;
      sweep_start = (state == IDLE) && cmd_ready_o && !cmd_valid_i && poll_pend;
      bus_resp    = sys_ack_i || sys_err_i;
      // Counter value equals cycles elapsed since the strobe cycle.
      tout_hit    = (state == WAIT) && !bus_resp && (tcnt == TW'(TIMEOUT));
      xfer_end    = ((state == STROBE) || (state == WAIT)) && (bus_resp || tout_hit);
      res_err     = sys_err_i || tout_hit;
      res_rdata   = (we || tout_hit) ? 32'd0 : sys_rdata_i;
      last_word   = (idx == KW'(POLL_NUM - 1));
      slot_we     = xfer_end && is_poll && !res_err;
   end

   // Main transaction sequencer; every output it drives is registered so the
   // bus strobes are glitch-free and drop immediately on reset.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state       <= IDLE;
         tcnt        <= '0;
         we          <= 1'b0;
         is_poll     <= 1'b0;
         sweep_err   <= 1'b0;
         idx         <= '0;
         cmd_ready_o <= 1'b0;
         rsp_valid_o <= 1'b0;
         rsp_rdata_o <= '0;
         rsp_err_o   <= 1'b0;
         rsp_tout_o  <= 1'b0;
         poll_upd_o  <= 1'b0;
         poll_err_o  <= 1'b0;
         sys_addr_o  <= '0;
         sys_wdata_o <= '0;
         sys_wen_o   <= 1'b0;
         sys_ren_o   <= 1'b0;
      end else begin
         rsp_valid_o <= 1'b0;
         poll_upd_o  <= 1'b0;
         sys_wen_o   <= 1'b0;
         sys_ren_o   <= 1'b0;

         case (state)
            IDLE: begin
               if (accept) begin
                  sys_addr_o  <= cmd_addr_i;
                  sys_wdata_o <= cmd_wdata_i;
                  we          <= cmd_we_i;
                  is_poll     <= 1'b0;
                  sys_wen_o   <= cmd_we_i;
                  sys_ren_o   <= !cmd_we_i;
                  tcnt        <= '0;
                  cmd_ready_o <= 1'b0;
                  state       <= STROBE;
               end else if (sweep_start) begin
                  sys_addr_o  <= POLL_BASE;
                  sys_wdata_o <= '0;
                  we          <= 1'b0;
                  is_poll     <= 1'b1;
                  idx         <= '0;
                  sweep_err   <= 1'b0;
                  sys_ren_o   <= 1'b1;
                  tcnt        <= '0;
                  cmd_ready_o <= 1'b0;
                  state       <= STROBE;
               end else begin
                  cmd_ready_o <= 1'b1;
               end
            end

            STROBE, WAIT: begin
               if (xfer_end) begin
                  state <= DONE;
                  if (!is_poll) begin
                     rsp_valid_o <= 1'b1;
                     rsp_rdata_o <= res_rdata;
                     rsp_err_o   <= res_err;
                     rsp_tout_o  <= tout_hit;
                  end else begin
                     // Sweep results are published on entry to DONE so that
                     // poll_data_o is already current when poll_upd_o pulses.
                     sweep_err <= sweep_err || res_err;
                     if (last_word) begin
                        poll_upd_o <= 1'b1;
                        poll_err_o <= sweep_err || res_err;
                     end
                  end
               end else begin
                  tcnt  <= tcnt + TW'(1);
                  state <= WAIT;
               end
            end

            DONE: begin
               if (is_poll && !last_word) begin
                  // Sweep is atomic: go straight to the next word.
                  idx        <= idx + KW'(1);
                  sys_addr_o <= sys_addr_o + 32'd4;
                  sys_ren_o  <= 1'b1;
                  tcnt       <= '0;
                  state      <= STROBE;
               end else begin
                  cmd_ready_o <= 1'b1;
                  state       <= IDLE;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Poll interval timer. A wrap while a sweep is still pending leaves the
   // single pend flag set, so missed intervals never queue extra sweeps.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         poll_timer <= '0;
         poll_pend  <= 1'b0;
      end else if (!poll_en_i) begin
         poll_timer <= '0;
         poll_pend  <= 1'b0;
      end else if (poll_timer == PW'(POLL_PERIOD - 1)) begin
         poll_timer <= '0;
         poll_pend  <= 1'b1;
      end else begin
         poll_timer <= poll_timer + PW'(1);
         if (sweep_start) begin
            poll_pend <= 1'b0;
         end
      end
   end

   // Poll cache: one register per word. A failed read leaves the old word.
   genvar gi;
   generate
      for (gi = 0; gi < POLL_NUM; gi++) begin : g_slot
         logic [31:0] word;

         always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
               word <= '0;
            end else if (slot_we && (idx == KW'(gi))) begin
               word <= sys_rdata_i;
            end
         end

         assign poll_data_o[32*gi +: 32] = word;
      end
   endgenerate

endmodule
